nxn_tic_tac_toe_game: RTL and testbench
=======================================

# nxn_tic_tac_toe_game

Parametrised N×N, K-in-a-row tic-tac-toe engine. It is the next-generation replacement for the fixed 3×3 game top. It owns the board registers, turn control, legality checking, a sequential win scanner around the last move, draw detection and an optional per-turn move timeout. It sits between the player input front-end (switch/button debounce) and the board display driver.

## Interface
- N, default 3: board side; legal range 3..8.
- K, default 3: run length that wins; legal range 3..N.
- TIMEOUT, default 0: clock cycles allowed per turn; 0 disables the timeout.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- new_game  in  1  synchronous restart; takes priority over everything except rst.
- move_valid  in  1  move request.
- move_player  in  1  0 = X, 1 = O.
- move_row, move_col  in  $clog2(N) each  target cell.
- move_ready  out  1  high in TURN_X/TURN_O only; combinational from state.
- board  out  2*N*N  cell (r,c) at bits [2*(r*N+c)+:2]; 00 empty, 01 X, 10 O.
- turn  out  1  player expected next (0 = X, 1 = O).
- who  out  2  00 none, 01 X wins, 10 O wins, 11 draw.
- game_over  out  1  high in DONE.
- illegal_move  out  1  one-cycle registered pulse on a rejected request.
- timed_out  out  1  high in DONE when the game ended by timeout.
- move_count  out  $clog2(N*N+1)  accepted moves this game.

## Operation
- States: TURN_X, TURN_O, CHECK, DONE.
- Reset/new_game: board all 00, who=00, game_over=0, timed_out=0, illegal_move=0, move_count=0, turn=0, state TURN_X, timer=0.
- Acceptance condition in TURN_x with move_valid=1: move_player equals the player on turn, row<N, col<N, and the target cell is 00.
- Accept: write the mover's code, latch mover/row/col, increment move_count, go to CHECK.
- Reject (any condition fails): board untouched, illegal_move=1 for the next cycle, state and timer unchanged.
- move_valid in CHECK or DONE is ignored. It produces no illegal pulse.
- CHECK scanner: directions in order horizontal, vertical, diagonal, anti-diagonal. For each direction, offsets t = -(K-1)..+(K-1) are visited, one cell per cycle.
- Run counter per direction: reset to 0 at the start of each direction. Increment when the cell is on-board and equals the mover's code; otherwise reset to 0.
- A win flag is set sticky when the run counter reaches K.
- No early exit: CHECK always lasts L = 4*(2K-1) cycles.
- End of CHECK:
  - win → DONE, who = mover's code.
  - Otherwise, move_count == N*N → DONE, who = 11.
  - Otherwise → the opponent's TURN state, turn toggled.
- Timeout (TIMEOUT>0): the timer clears on entering a TURN state and counts cycles spent in it. When TIMEOUT cycles elapse without an accepted move → DONE, who = opponent's code, timed_out=1.
- DONE holds board, who and flags until new_game or rst.

## Timing
- Move accepted at edge E: board and move_count update at E, move_ready falls after E.
- CHECK occupies cycles E+1..E+L. The result (next TURN or DONE, who) is registered at edge E+L.
- With N=K=3, L=20.
- illegal_move is high for exactly the cycle after the rejecting edge. It pulses every cycle while an illegal request is held.
- A legal move presented in the final timeout cycle is accepted; the timeout does not fire.
- new_game asserted together with move_valid: restart wins, move discarded.
- rst asserted mid-CHECK: all state clears immediately to reset values. No partial result is ever produced.
- Arithmetic: row/col offsets are computed signed, one bit wider than $clog2(N). Any coordinate <0 or ≥N is off-board and never indexes board.

## Test plan
- N=3,K=3: X(0,0), O(1,0), X(0,1), O(1,1), X(0,2) → after the 5th acceptance +20 cycles: who=01, game_over=1, move_count=5, board[5:0]=010101.
- N=3: X(1,1) then O(1,1) → illegal_move one pulse, board unchanged, turn=1. Next, O sends a request with move_player=0 → illegal pulse, turn stays O.
- N=3 draw sequence X00, O01, X02, O11, X10, O12, X21, O20, X22 → who=11, move_count=9, timed_out=0.
- N=5,K=4: O anti-diagonal (0,4),(1,3),(2,2),(3,1) with X elsewhere, no X run → who=10 exactly 28 cycles after the last acceptance. Also check that a 3-run with an off-board edge does not win.
- TIMEOUT=16: no move for X → at cycle 16 in TURN_X: who=10, timed_out=1. Repeat with a legal move at cycle 15 → accepted, no timeout.
- rst low during CHECK, then new_game during DONE → all outputs at reset values, state TURN_X, move_ready=1.

Source files
------------

// File: rtl/nxn_tic_tac_toe_game.sv
// N x N, K-in-a-row tic-tac-toe engine. It holds the board, checks each move for
// legality, scans around the last move one cell per cycle, and detects draws and turn timeouts.
module nxn_tic_tac_toe_game #(
  parameter int N       = 3,
  parameter int K       = 3,
  parameter int TIMEOUT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         new_game,
  input  logic                         move_valid,
  input  logic                         move_player,
  input  logic [$clog2(N)-1:0]         move_row,
  input  logic [$clog2(N)-1:0]         move_col,
  output logic                         move_ready,
  output logic [2*N*N-1:0]             board,
  output logic                         turn,
  output logic [1:0]                   who,
  output logic                         game_over,
  output logic                         illegal_move,
  output logic                         timed_out,
  output logic [$clog2(N*N+1)-1:0]     move_count
);

  localparam int RW  = $clog2(N);
  localparam int SW  = RW + 1;
  localparam int CW  = $clog2(N*N+1);
  localparam int IW  = $clog2(N*N);
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
  localparam int RNW = $clog2(K+1);
  localparam logic [RW:0] NU = (RW+1)'(N);

  typedef enum logic [1:0] {TURN_X, TURN_O, CHECK, DONE} state_t;

  state_t          state;
  logic [1:0]      dir_q;
  logic [SW-1:0]   t_q;
  logic [RNW-1:0]  run_q;
  logic            win_q;
  logic            mover_q;
  logic [RW-1:0]   row_q, col_q;
  logic [TW-1:0]   timer_q;

  assign move_ready = (state == TURN_X) || (state == TURN_O);

  // Scanner: walks offset -(K-1)..+(K-1) around the last move in one direction.
  // Coordinates that wrap in SW bits always come out negative, so they are off-board.
  logic signed [SW-1:0] off, rs, cs, sr, sc;
  logic                 on_board, hit, win_now, last_t, scan_end;
  logic [IW-1:0]        sidx;
  logic [1:0]           scell, mcode;
  logic [RNW-1:0]       run_nxt;

  always_comb begin
    off = $signed(t_q) - $signed(SW'(K-1));
    rs  = $signed({1'b0, row_q});
    cs  = $signed({1'b0, col_q});
    sr  = rs;
    sc  = cs;
    unique case (dir_q)
      2'd0:    sc = cs + off;
      2'd1:    sr = rs + off;
      2'd2:    begin sr = rs + off; sc = cs + off; end
      default: begin sr = rs + off; sc = cs - off; end
    endcase
    on_board = !sr[SW-1] && !sc[SW-1] &&
               ({1'b0, sr[RW-1:0]} < NU) && ({1'b0, sc[RW-1:0]} < NU);
    sidx     = on_board ? IW'(int'(sr[RW-1:0]) * N + int'(sc[RW-1:0])) : '0;
    scell    = board[2*sidx +: 2];
    mcode    = mover_q ? 2'b10 : 2'b01;
    hit      = on_board && (scell == mcode);
    run_nxt  = hit ? run_q + 1'b1 : '0;
    win_now  = win_q || (run_nxt == RNW'(K));
    last_t   = (t_q == SW'(2*K-2));
    scan_end = last_t && (dir_q == 2'd3);
  end

  // Acceptance of a move request
  logic          row_ok, col_ok, acc_ok;
  logic [IW-1:0] midx;
  logic [1:0]    mcell;

  always_comb begin
    row_ok = ({1'b0, move_row} < NU);
    col_ok = ({1'b0, move_col} < NU);
    midx   = (row_ok && col_ok) ? IW'(int'(move_row) * N + int'(move_col)) : '0;
    mcell  = board[2*midx +: 2];
    acc_ok = (move_player == turn) && row_ok && col_ok && (mcell == 2'b00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= TURN_X;
      board        <= '0;
      turn         <= 1'b0;
      who          <= 2'b00;
      game_over    <= 1'b0;
      illegal_move <= 1'b0;
      timed_out    <= 1'b0;
      move_count   <= '0;
      dir_q        <= '0;
      t_q          <= '0;
      run_q        <= '0;
      win_q        <= 1'b0;
      mover_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      timer_q      <= '0;
    end else if (new_game) begin
      state        <= TURN_X;
      board        <= '0;
      turn         <= 1'b0;
      who          <= 2'b00;
      game_over    <= 1'b0;
      illegal_move <= 1'b0;
      timed_out    <= 1'b0;
      move_count   <= '0;
      dir_q        <= '0;
      t_q          <= '0;
      run_q        <= '0;
      win_q        <= 1'b0;
      mover_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      timer_q      <= '0;
    end else begin
      illegal_move <= 1'b0;
      unique case (state)
        TURN_X, TURN_O: begin
          if (move_valid && acc_ok) begin
            board[2*midx +: 2] <= move_player ? 2'b10 : 2'b01;
            mover_q    <= move_player;
            row_q      <= move_row;
            col_q      <= move_col;
            move_count <= move_count + 1'b1;
            dir_q      <= '0;
            t_q        <= '0;
            run_q      <= '0;
            win_q      <= 1'b0;
            state      <= CHECK;
          end else if (move_valid) begin
            illegal_move <= 1'b1;
          end else if ((TIMEOUT > 0) && (timer_q == TW'(TIMEOUT-1))) begin
            who       <= (state == TURN_X) ? 2'b10 : 2'b01;
            timed_out <= 1'b1;
            game_over <= 1'b1;
            state     <= DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        CHECK: begin
          win_q <= win_now;
          run_q <= last_t ? '0 : run_nxt;
          if (last_t) begin
            t_q   <= '0;
            dir_q <= dir_q + 1'b1;
          end else begin
            t_q <= t_q + 1'b1;
          end
          // No early exit: the result lands only after all four directions.
          if (scan_end) begin
            if (win_now) begin
              who       <= mcode;
              game_over <= 1'b1;
              state     <= DONE;
            end else if (move_count == CW'(N*N)) begin
              who       <= 2'b11;
              game_over <= 1'b1;
              state     <= DONE;
            end else begin
              turn    <= ~mover_q;
              timer_q <= '0;
              state   <= mover_q ? TURN_X : TURN_O;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nxn_tic_tac_toe_game.sv
// Directed bench: 3x3 win/illegal/draw, 5x5 K=4 anti-diagonal, 3x3 with a
// 16-cycle timeout, and async reset in the middle of a scan.
module tb_nxn_tic_tac_toe_game;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // A: N=3 K=3, no timeout
  logic        a_ng, a_v, a_p, a_ready, a_turn, a_over, a_ill, a_to;
  logic [1:0]  a_r, a_c, a_who;
  logic [17:0] a_board;
  logic [3:0]  a_cnt;
  // B: N=5 K=4
  logic        b_ng, b_v, b_p, b_ready, b_turn, b_over, b_ill, b_to;
  logic [2:0]  b_r, b_c;
  logic [1:0]  b_who;
  logic [49:0] b_board;
  logic [4:0]  b_cnt;
  // C: N=3 K=3, TIMEOUT=16
  logic        c_ng, c_v, c_p, c_ready, c_turn, c_over, c_ill, c_to;
  logic [1:0]  c_r, c_c, c_who;
  logic [17:0] c_board;
  logic [3:0]  c_cnt;

  nxn_tic_tac_toe_game #(.N(3), .K(3), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst(rst), .new_game(a_ng), .move_valid(a_v), .move_player(a_p),
    .move_row(a_r), .move_col(a_c), .move_ready(a_ready), .board(a_board), .turn(a_turn),
    .who(a_who), .game_over(a_over), .illegal_move(a_ill), .timed_out(a_to), .move_count(a_cnt));

  nxn_tic_tac_toe_game #(.N(5), .K(4), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .new_game(b_ng), .move_valid(b_v), .move_player(b_p),
    .move_row(b_r), .move_col(b_c), .move_ready(b_ready), .board(b_board), .turn(b_turn),
    .who(b_who), .game_over(b_over), .illegal_move(b_ill), .timed_out(b_to), .move_count(b_cnt));

  nxn_tic_tac_toe_game #(.N(3), .K(3), .TIMEOUT(16)) dut_c (
    .clk(clk), .rst(rst), .new_game(c_ng), .move_valid(c_v), .move_player(c_p),
    .move_row(c_r), .move_col(c_c), .move_ready(c_ready), .board(c_board), .turn(c_turn),
    .who(c_who), .game_over(c_over), .illegal_move(c_ill), .timed_out(c_to), .move_count(c_cnt));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mova(input logic p, input logic [1:0] r, input logic [1:0] c);
    a_v = 1'b1; a_p = p; a_r = r; a_c = c;
    cyc(1);
    a_v = 1'b0;
  endtask

  task automatic movb(input logic p, input logic [2:0] r, input logic [2:0] c);
    b_v = 1'b1; b_p = p; b_r = r; b_c = c;
    cyc(1);
    b_v = 1'b0;
  endtask

  task automatic movc(input logic p, input logic [1:0] r, input logic [1:0] c);
    c_v = 1'b1; c_p = p; c_r = r; c_c = c;
    cyc(1);
    c_v = 1'b0;
  endtask

  task automatic nga();
    a_ng = 1'b1; cyc(1); a_ng = 1'b0;
  endtask

  task automatic ngc();
    c_ng = 1'b1; cyc(1); c_ng = 1'b0;
  endtask

  logic       dp [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  logic [1:0] dr [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  logic [1:0] dc [9] = '{0, 1, 2, 1, 0, 2, 1, 0, 2};

  initial begin
    {a_ng, a_v, a_p, a_r, a_c} = '0;
    {b_ng, b_v, b_p, b_r, b_c} = '0;
    {c_ng, c_v, c_p, c_r, c_c} = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #11;
    chk("rst_board", a_board, 18'h0);
    chk("rst_who", a_who, 2'b00);
    chk("rst_over", a_over, 1'b0);
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_turn", a_turn, 1'b0);
    chk("rst_cnt", a_cnt, 4'd0);
    chk("rst_ill", a_ill, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Timeout: X idles for 16 cycles
    ngc();
    cyc(15);
    chk("to_early_over", c_over, 1'b0);
    cyc(1);
    chk("to_who", c_who, 2'b10);
    chk("to_flag", c_to, 1'b1);
    chk("to_over", c_over, 1'b1);
    chk("to_ready", c_ready, 1'b0);
    ngc();
    chk("ng_board", c_board, 18'h0);
    chk("ng_who", c_who, 2'b00);
    chk("ng_over", c_over, 1'b0);
    chk("ng_to", c_to, 1'b0);
    chk("ng_ready", c_ready, 1'b1);
    chk("ng_cnt", c_cnt, 4'd0);
    chk("ng_turn", c_turn, 1'b0);
    // Legal move in the last timeout cycle
    cyc(15);
    movc(1'b0, 2'd1, 2'd1);
    chk("to_last_over", c_over, 1'b0);
    chk("to_last_cnt", c_cnt, 4'd1);
    chk("to_last_to", c_to, 1'b0);
    chk("to_last_ready", c_ready, 1'b0);
    cyc(20);
    chk("to_o_turn", c_turn, 1'b1);
    cyc(15);
    chk("to_o_early", c_over, 1'b0);
    cyc(1);
    chk("to_o_who", c_who, 2'b01);
    chk("to_o_flag", c_to, 1'b1);

    // 3x3 X row win
    nga();
    mova(1'b0, 2'd0, 2'd0);
    chk("win_ready_low", a_ready, 1'b0);
    chk("win_cnt1", a_cnt, 4'd1);
    chk("win_board1", a_board, 18'h00001);
    cyc(20);
    chk("win_turn_o", a_turn, 1'b1);
    chk("win_ready_hi", a_ready, 1'b1);
    mova(1'b1, 2'd1, 2'd0); cyc(20);
    mova(1'b0, 2'd0, 2'd1); cyc(20);
    mova(1'b1, 2'd1, 2'd1); cyc(20);
    mova(1'b0, 2'd0, 2'd2);
    cyc(19);
    chk("win_early", a_over, 1'b0);
    cyc(1);
    chk("win_who", a_who, 2'b01);
    chk("win_over", a_over, 1'b1);
    chk("win_cnt", a_cnt, 4'd5);
    chk("win_row0", a_board[5:0], 6'b010101);
    chk("win_board", a_board, 18'h00295);
    chk("win_to", a_to, 1'b0);
    mova(1'b1, 2'd2, 2'd2);
    chk("done_ign_ill", a_ill, 1'b0);
    chk("done_ign_board", a_board, 18'h00295);

    // new_game beats a simultaneous move
    a_ng = 1'b1; a_v = 1'b1; a_p = 1'b0; a_r = 2'd0; a_c = 2'd0;
    cyc(1);
    a_ng = 1'b0; a_v = 1'b0;
    chk("ngmv_board", a_board, 18'h0);
    chk("ngmv_cnt", a_cnt, 4'd0);
    chk("ngmv_ready", a_ready, 1'b1);
    chk("ngmv_who", a_who, 2'b00);

    // Illegal moves
    mova(1'b0, 2'd1, 2'd1); cyc(20);
    mova(1'b1, 2'd1, 2'd1);
    chk("occ_ill", a_ill, 1'b1);
    chk("occ_board", a_board, 18'h00100);
    chk("occ_turn", a_turn, 1'b1);
    cyc(1);
    chk("occ_ill_drop", a_ill, 1'b0);
    a_v = 1'b1; a_p = 1'b0; a_r = 2'd0; a_c = 2'd0;
    cyc(1);
    chk("wrong_ill1", a_ill, 1'b1);
    cyc(1);
    chk("wrong_ill2", a_ill, 1'b1);
    a_v = 1'b0;
    cyc(1);
    chk("wrong_ill_drop", a_ill, 1'b0);
    chk("wrong_turn", a_turn, 1'b1);
    chk("wrong_board", a_board, 18'h00100);
    mova(1'b1, 2'd3, 2'd0);
    chk("offrow_ill", a_ill, 1'b1);
    chk("offrow_ready", a_ready, 1'b1);

    // Draw
    nga();
    for (int i = 0; i < 9; i++) begin
      mova(dp[i], dr[i], dc[i]);
      cyc(20);
    end
    chk("draw_who", a_who, 2'b11);
    chk("draw_cnt", a_cnt, 4'd9);
    chk("draw_to", a_to, 1'b0);
    chk("draw_over", a_over, 1'b1);
    chk("draw_board", a_board, 18'h16A59);

    // 5x5 K=4: edge 3-run no win, then O anti-diagonal
    movb(1'b0, 3'd5, 3'd0);
    chk("b_offrow_ill", b_ill, 1'b1);
    movb(1'b0, 3'd0, 3'd0); cyc(28);
    movb(1'b1, 3'd0, 3'd4); cyc(28);
    movb(1'b0, 3'd0, 3'd1); cyc(28);
    movb(1'b1, 3'd1, 3'd3); cyc(28);
    movb(1'b0, 3'd0, 3'd2); cyc(28);
    chk("b_run3_over", b_over, 1'b0);
    chk("b_run3_who", b_who, 2'b00);
    chk("b_run3_turn", b_turn, 1'b1);
    movb(1'b1, 3'd2, 3'd2); cyc(28);
    movb(1'b0, 3'd4, 3'd4); cyc(28);
    movb(1'b1, 3'd3, 3'd1);
    cyc(27);
    chk("b_early_over", b_over, 1'b0);
    chk("b_early_who", b_who, 2'b00);
    cyc(1);
    chk("b_who", b_who, 2'b10);
    chk("b_over", b_over, 1'b1);
    chk("b_cnt", b_cnt, 5'd8);

    // Async reset mid-CHECK
    nga();
    mova(1'b0, 2'd2, 2'd2);
    cyc(5);
    rst = 1'b0;
    #1;
    chk("mrst_board", a_board, 18'h0);
    chk("mrst_cnt", a_cnt, 4'd0);
    chk("mrst_ready", a_ready, 1'b1);
    chk("mrst_over", a_over, 1'b0);
    chk("mrst_who", a_who, 2'b00);
    chk("mrst_turn", a_turn, 1'b0);
    rst = 1'b1;
    cyc(25);
    chk("mrst_after_ready", a_ready, 1'b1);
    chk("mrst_after_who", a_who, 2'b00);
    chk("mrst_after_board", a_board, 18'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
